// File: rtl/sel_mux_pipe_pkg.sv
// sel_mux_pkg: channel limits and grant/index types shared by sel_mux_pipe and rr_arbiter.
package sel_mux_pkg;

  localparam int MAX_CHANNELS = 16;
  localparam int CHAN_IDX_W   = $clog2(MAX_CHANNELS);

  typedef logic [CHAN_IDX_W-1:0]   chan_idx_t;
  typedef logic [MAX_CHANNELS-1:0] grant_t;

  // Next channel index after idx, wrapping back to 0 at n channels.
  function automatic chan_idx_t wrap_inc(chan_idx_t idx, int n);
    return (int'(idx) + 1 >= n) ? '0 : idx + chan_idx_t'(1);
  endfunction

endpackage

// File: rtl/sel_mux_pipe_rr_arbiter.sv
// rr_arbiter: round-robin grant over a request vector; only built when SEL_MUX_PIPE_RR_EN is defined.
`ifdef SEL_MUX_PIPE_RR_EN
module rr_arbiter
  import sel_mux_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  chan_idx_t r_ptr;
  logic      r_fresh;
  int        w_start;
  int        w_dist;
  int        w_best;

  // Until the first transfer after reset the search begins at channel 0 rather than pointer+1.
  assign w_start = r_fresh ? 0 : int'(wrap_inc(r_ptr, N));

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_dist  = 0;
    w_best  = N;
    for (int c = 0; c < N; c++) begin
      w_dist = (c >= w_start) ? (c - w_start) : (c + N - w_start);
      if (i_req[c] && (w_dist < w_best)) begin
        w_best     = w_dist;
        o_idx      = IW'(c);
        o_grant    = '0;
        o_grant[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_ptr   <= '0;
      r_fresh <= 1'b1;
    end else if (i_advance && (|o_grant)) begin
      r_ptr   <= chan_idx_t'(o_idx);
      r_fresh <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/sel_mux_pipe.sv
// sel_mux_pipe: CHANNELS-to-1 valid/ready mux feeding a single registered output stage.
// Define SEL_MUX_PIPE_RR_EN to make rr_mode=1 select round-robin arbitration.
module sel_mux_pipe
  import sel_mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 3,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                cs,
  input  logic [SEL_W-1:0]    sel,
  input  logic                rr_mode,
  input  logic [CHANNELS-1:0] in_valid,
  input  logic [WIDTH-1:0]    in_data [CHANNELS],
  output logic [CHANNELS-1:0] in_ready,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic [SEL_W-1:0]    out_chan,
  input  logic                out_ready
);

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [SEL_W-1:0]    r_out_chan;
  logic [CHANNELS-1:0] w_fix_grant;
  logic [CHANNELS-1:0] w_grant;
  logic [SEL_W-1:0]    w_grant_idx;
  logic                w_can_load;
  logic                w_xfer;
  logic [WIDTH-1:0]    w_push_data;

  // nReset gates the accept path so in_ready is low throughout reset.
  assign w_can_load = nReset && cs && (!r_out_valid || out_ready);

  // A sel value at or beyond CHANNELS matches no bit, so nothing is granted.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_fix
      assign w_fix_grant[gi] = (sel == SEL_W'(gi));
    end
  endgenerate

`ifdef SEL_MUX_PIPE_RR_EN
  logic [CHANNELS-1:0] w_rr_grant;
  logic [SEL_W-1:0]    w_rr_idx;

  rr_arbiter #(
    .N  (CHANNELS),
    .IW (SEL_W)
  ) u_rr_arbiter (
    .clk       (clk),
    .nReset    (nReset),
    .i_req     (in_valid),
    .i_advance (rr_mode && w_xfer),
    .o_grant   (w_rr_grant),
    .o_idx     (w_rr_idx)
  );

  assign w_grant     = rr_mode ? w_rr_grant : w_fix_grant;
  assign w_grant_idx = rr_mode ? w_rr_idx   : sel;
`else
  logic w_unused_rr_mode;
  assign w_unused_rr_mode = rr_mode;
  assign w_grant          = w_fix_grant;
  assign w_grant_idx      = sel;
`endif

  assign in_ready = w_can_load ? w_grant : '0;
  assign w_xfer   = |(in_valid & in_ready);

  always_comb begin
    w_push_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant[i]) w_push_data = in_data[i];
    end
  end

  // Push wins over pop so a simultaneous pop+push refills with no bubble.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_push_data;
      r_out_chan  <= w_grant_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// tb_sel_mux_pipe: directed + random stimulus with a scoreboard of expected output items.
module tb_sel_mux_pipe;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 3;
  localparam int SEL_W    = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] chan;
  } item_t;

  logic                clk;
  logic                nReset;
  logic                cs;
  logic [SEL_W-1:0]    sel;
  logic                rr_mode;
  logic [CHANNELS-1:0] in_valid;
  logic [WIDTH-1:0]    in_data [CHANNELS];
  logic [CHANNELS-1:0] in_ready;
  logic                out_valid;
  logic [WIDTH-1:0]    out_data;
  logic [SEL_W-1:0]    out_chan;
  logic                out_ready;

  item_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_fail   = 0;
`ifdef SEL_MUX_PIPE_RR_EN
  int    m_ptr    = 0;
  bit    m_fresh  = 1'b1;
`endif

  sel_mux_pipe #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk       (clk),
    .nReset    (nReset),
    .cs        (cs),
    .sel       (sel),
    .rr_mode   (rr_mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference grant: round-robin from the modelled pointer when enabled, else sel.
  task automatic model_grant(output logic ok, output logic [SEL_W-1:0] g);
    ok = 1'b0;
    g  = '0;
`ifdef SEL_MUX_PIPE_RR_EN
    if (rr_mode) begin
      int start;
      start = m_fresh ? 0 : (m_ptr + 1) % CHANNELS;
      for (int k = 0; k < CHANNELS; k++) begin
        int c;
        c = (start + k) % CHANNELS;
        if (!ok && in_valid[c]) begin
          ok = 1'b1;
          g  = SEL_W'(c);
        end
      end
      return;
    end
`endif
    if (int'(sel) < CHANNELS) begin
      ok = 1'b1;
      g  = sel;
    end
  endtask

  // One clock: check ready/output against the scoreboard, update it, then advance.
  task automatic cycle();
    logic                ok;
    logic [SEL_W-1:0]    g;
    logic [CHANNELS-1:0] exp_rdy;
    item_t               it;
    #1;
    model_grant(ok, g);
    exp_rdy = '0;
    if (nReset && cs && (sb.size() == 0 || out_ready) && ok) exp_rdy[g] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      it = sb[0];
      check("out_data", 32'(out_data), 32'(it.data));
      check("out_chan", 32'(out_chan), 32'(it.chan));
      if (out_ready) begin
        void'(sb.pop_front());
        $display("pop  chan=%0d data=%02h", it.chan, it.data);
      end
    end else begin
      check("out_data_idle", 32'(out_data), 32'd0);
      check("out_chan_idle", 32'(out_chan), 32'd0);
    end
    if (exp_rdy != '0 && in_valid[g]) begin
      sb.push_back(item_t'{data: in_data[g], chan: g});
`ifdef SEL_MUX_PIPE_RR_EN
      if (rr_mode) begin
        m_ptr   = int'(g);
        m_fresh = 1'b0;
      end
`endif
      $display("push chan=%0d data=%02h", g, in_data[g]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic [SEL_W-1:0] s, input logic r,
                       input logic [CHANNELS-1:0] v, input logic o);
    cs        = c;
    sel       = s;
    rr_mode   = r;
    in_valid  = v;
    out_ready = o;
  endtask

  initial begin
    nReset = 1'b0;
    drive(1'b1, 2'd0, 1'b0, 3'b111, 1'b1);
    for (int i = 0; i < CHANNELS; i++) in_data[i] = 8'(8'h10 + i);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_chan", 32'(out_chan), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    cs = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    @(posedge clk);
    #1;

    // Fixed select of channel 1, then drain.
    drive(1'b1, 2'd1, 1'b0, 3'b010, 1'b1);
    in_data[1] = 8'hA5;
    cycle();
    check("fixed_a5_data", 32'(out_data), 32'hA5);
    check("fixed_a5_chan", 32'(out_chan), 32'd1);
    drive(1'b0, 2'd1, 1'b0, 3'b000, 1'b1);
    cycle();

    // Out-of-range select grants nothing.
    drive(1'b1, 2'd3, 1'b0, 3'b111, 1'b1);
    repeat (4) cycle();

    // Backpressure with new data offered, then pop+push with no bubble.
    drive(1'b1, 2'd0, 1'b0, 3'b001, 1'b1);
    in_data[0] = 8'h11;
    cycle();
    in_data[0] = 8'h22;
    out_ready  = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b1;
    cycle();
    check("no_bubble_data", 32'(out_data), 32'h22);
    in_valid = 3'b000;
    cycle();
    cycle();

    // cs drop while holding data.
    drive(1'b1, 2'd0, 1'b0, 3'b001, 1'b1);
    in_data[0] = 8'h3C;
    cycle();
    drive(1'b0, 2'd0, 1'b0, 3'b111, 1'b0);
    repeat (2) cycle();
    out_ready = 1'b1;
    cycle();
    cycle();

    // sel/rr_mode changes while holding must not disturb the held item.
    drive(1'b1, 2'd2, 1'b0, 3'b100, 1'b1);
    in_data[2] = 8'h5A;
    cycle();
    drive(1'b1, 2'd0, 1'b1, 3'b111, 1'b0);
    repeat (2) cycle();
    drive(1'b1, 2'd1, 1'b0, 3'b000, 1'b1);
    repeat (2) cycle();

    // rr_mode=1 with all valid, then with 3'b101.
    drive(1'b1, 2'd1, 1'b1, 3'b111, 1'b1);
    for (int i = 0; i < CHANNELS; i++) in_data[i] = 8'(8'hC0 + i);
    repeat (5) cycle();
    in_valid = 3'b101;
    repeat (4) cycle();
    in_valid = 3'b000;
    repeat (2) cycle();

    // Random traffic.
    repeat (80) begin
      drive($urandom_range(0, 3) != 0, SEL_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            CHANNELS'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
      for (int i = 0; i < CHANNELS; i++) in_data[i] = 8'($urandom_range(0, 255));
      cycle();
    end

    // Asynchronous reset mid-stream, between clock edges.
    drive(1'b1, 2'd2, 1'b1, 3'b111, 1'b1);
    repeat (3) cycle();
    #3;
    nReset = 1'b0;
    cs     = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", 32'(out_data), 32'd0);
    check("async_rst_chan", 32'(out_chan), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd0);
    sb.delete();
`ifdef SEL_MUX_PIPE_RR_EN
    m_ptr   = 0;
    m_fresh = 1'b1;
`endif
    @(negedge clk);
    nReset = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 2'd2, 1'b1, 3'b111, 1'b1);
    repeat (4) cycle();
    in_valid = 3'b000;
    repeat (2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sel_mux_pipe.md
SEL_MUX_PIPE -- requirements
Module: sel_mux_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bits per channel.
REQ-002 The block SHALL have parameter CHANNELS, default 3, meaning number of input channels (legal range 2..16).
REQ-003 The block SHALL have derived localparam SEL_W = $clog2(CHANNELS), meaning the select and channel-index width.
REQ-004 The block SHALL have these ports, one per line, in this order:
- clk  input  1  single clock, all state on rising edge.
- nReset  input  1  asynchronous, active-low reset.
- cs  input  1  chip select; 0 = no channel accepted.
- sel  input  SEL_W  fixed-mode channel select.
- rr_mode  input  1  1 = round-robin arbitration, 0 = sel-driven.
- in_valid  input  CHANNELS  per-channel data valid.
- in_data  input  CHANNELS x WIDTH  per-channel data (unpacked array).
- in_ready  output  CHANNELS  per-channel accept.
- out_valid  output  1  output register holds data.
- out_data  output  WIDTH  registered data.
- out_chan  output  SEL_W  source channel of out_data.
- out_ready  input  1  downstream accept.

Function
REQ-005 The block SHALL hold a single-entry output register; a transfer on channel i occurs when in_valid[i] && in_ready[i].
REQ-006 in_ready[i] SHALL be 1 only when cs=1, i is the granted channel, and (out_valid=0 || out_ready=1); at most one in_ready bit SHALL be high per cycle.
REQ-007 In fixed mode (rr_mode=0), the granted channel SHALL be sel; if sel >= CHANNELS, no channel SHALL be granted.
REQ-008 Latency: data accepted in cycle N SHALL appear on out_data with out_valid=1 in cycle N+1, with out_chan = granted index.
REQ-009 When out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL hold unchanged and all in_ready SHALL be 0.
REQ-010 Simultaneous pop and push (out_valid && out_ready && transfer) SHALL replace the register contents with no bubble cycle.
REQ-011 Pop without push SHALL clear out_valid and SHALL drive out_data and out_chan to 0.
REQ-012 out_data and out_chan SHALL be 0 whenever out_valid=0.
REQ-013 cs falling while out_valid=1 SHALL NOT discard held data; it SHALL drain normally on out_ready.
REQ-014 rr_mode and sel changes SHALL take effect in the same cycle; they SHALL NOT disturb held output data.

Reset
REQ-015 While nReset=0, out_valid, out_data, out_chan and the round-robin pointer SHALL be 0, asynchronously.
REQ-016 in_ready SHALL be all 0 while nReset=0.
REQ-017 Reset mid-transfer SHALL discard held data; the first post-reset grant in round-robin mode SHALL search from channel 0.

Configuration
REQ-018 Macro SEL_MUX_PIPE_RR_EN defined: rr_mode=1 SHALL grant the lowest-index valid channel at or after pointer+1 (modulo CHANNELS), and the pointer SHALL update to the granted index only on a transfer.
REQ-019 Macro undefined: rr_mode port SHALL remain present but be ignored; behaviour SHALL be fixed mode only, and no pointer logic SHALL be synthesised.

Structure
REQ-020 Package sel_mux_pkg SHALL hold the MAX_CHANNELS=16 constant and the typedef for the grant/index type.
REQ-021 Round-robin grant logic SHALL be a sub-module named rr_arbiter (request vector, pointer, advance in; one-hot grant and index out), instantiated only under SEL_MUX_PIPE_RR_EN.

Verification
REQ-022 Fixed mode: cs=1, sel=1, in_valid=3'b010, in_data[1]=8'hA5, out_ready=1 -> in_ready=3'b010; next cycle out_valid=1, out_data=8'hA5, out_chan=1.
REQ-023 Invalid select: sel=3 with CHANNELS=3, all in_valid=1 -> in_ready=0 and out_valid stays 0 for 4 cycles.
REQ-024 Backpressure: out_valid=1 holding 8'h11, out_ready=0 for 3 cycles with new data offered -> out_data stays 8'h11 and in_ready=0; after out_ready=1, the next item appears the following cycle with no bubble.
REQ-025 cs drop: cs=0 while holding 8'h3C -> in_ready=0; out_ready=1 -> 8'h3C delivered, then out_valid=0 and out_data=0.
REQ-026 Round-robin (macro defined): rr_mode=1, all in_valid=1, out_ready=1 -> out_chan sequence 0,1,2,0 on consecutive cycles; with in_valid=3'b101 -> sequence 0,2,0.
REQ-027 Async reset: assert nReset=0 mid-stream between clock edges -> out_valid, out_data and out_chan are 0 immediately; after release, round-robin grants start at channel 0.
